// File: rtl/lfsr_gen.sv
`timescale 1ns/1ps
// lfsr_gen: Fibonacci LFSR with all-zero lockup recovery, step counter and
// period-length measurement. The step counter restarts from each start
// point: reset, load, or recovery.
module lfsr_gen #(
    parameter int              WIDTH = 12,
    parameter logic [WIDTH-1:0] TAPS = 12'h829,
    parameter logic [WIDTH-1:0] SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH:0]   out_offset,
    output logic [WIDTH-1:0] step_cnt,
    output logic [WIDTH-1:0] period_len,
    output logic             period_done,
    output logic             lockup
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_start;
    logic [WIDTH-1:0] r_step_cnt;
    logic [WIDTH-1:0] r_period_len;
    logic             r_period_done;
    logic             r_lockup;

    logic [WIDTH-1:0] w_tap_bits;
    logic             w_fb;
    logic [WIDTH-1:0] w_next_step;
    logic [WIDTH-1:0] w_cnt_inc;
    logic             w_is_zero;

    // Mask each state bit with its tap; the feedback is the parity of the taps.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_tap
            assign w_tap_bits[gi] = r_out[gi] & TAPS[gi];
        end
    endgenerate

    assign w_fb        = ^w_tap_bits;
    assign w_next_step = {r_out[WIDTH-2:0], w_fb};
    assign w_cnt_inc   = r_step_cnt + ONE;
    assign w_is_zero   = (r_out == '0);

    // State update. Priority: reset > load > lockup recovery > step > hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out         <= SEED;
            r_start       <= SEED;
            r_step_cnt    <= '0;
            r_period_len  <= '0;
            r_period_done <= 1'b0;
            r_lockup      <= 1'b0;
        end else if (load) begin
            // A loaded value becomes the new start point; en is ignored.
            r_out         <= load_val;
            r_start       <= load_val;
            r_step_cnt    <= '0;
            r_period_done <= 1'b0;
            r_lockup      <= 1'b0;
        end else if (en && w_is_zero) begin
            // All-zero state never leaves by stepping: reseed instead of stepping.
            r_out         <= SEED;
            r_start       <= SEED;
            r_step_cnt    <= '0;
            r_period_done <= 1'b0;
            r_lockup      <= 1'b1;
        end else if (en) begin
            r_out    <= w_next_step;
            r_lockup <= 1'b0;
            if (w_next_step == r_start) begin
                // Returning to the start point closes one period.
                r_period_len  <= w_cnt_inc;
                r_step_cnt    <= '0;
                r_period_done <= 1'b1;
            end else begin
                r_step_cnt    <= w_cnt_inc;
                r_period_done <= 1'b0;
            end
        end else begin
            r_period_done <= 1'b0;
            r_lockup      <= 1'b0;
        end
    end

    assign out         = r_out;
    assign out_offset  = {1'b1, r_out};
    assign step_cnt    = r_step_cnt;
    assign period_len  = r_period_len;
    assign period_done = r_period_done;
    assign lockup      = r_lockup;

endmodule

// File: tb/tb_lfsr_gen.sv
`timescale 1ns/1ps
// tb_lfsr_gen: directed bench for lfsr_gen (WIDTH=12, TAPS=0x829, SEED=1).
// An arithmetic reference model is compared on every falling edge; directed
// literal expectations pin the model to hand-computed values.
module tb_lfsr_gen;

    localparam int W      = 12;
    localparam int MOD    = 4096;
    localparam int TB_TAP = 'h829;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          load;
    logic [W-1:0]  load_val;
    logic [W-1:0]  out;
    logic [W:0]    out_offset;
    logic [W-1:0]  step_cnt;
    logic [W-1:0]  period_len;
    logic          period_done;
    logic          lockup;

    int checks = 0;
    int errors = 0;
    int pd_pulses = 0;
    bit verbose = 1'b1;

    lfsr_gen #(.WIDTH(12), .TAPS(12'h829), .SEED(12'h001)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .load_val    (load_val),
        .out         (out),
        .out_offset  (out_offset),
        .step_cnt    (step_cnt),
        .period_len  (period_len),
        .period_done (period_done),
        .lockup      (lockup)
    );

    always #5 clk = ~clk;

    // Reference model: state as plain integers, next value via shift-by-multiply
    // plus the parity of the tapped bits.
    int m_out = 1, m_start = 1, m_cnt = 0, m_plen = 0;
    bit m_pd = 1'b0, m_lk = 1'b0;

    function automatic int next_val(input int s);
        return ((s * 2) % MOD) + ($countones(s & TB_TAP) % 2);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_out <= 1; m_start <= 1; m_cnt <= 0; m_plen <= 0;
            m_pd <= 1'b0; m_lk <= 1'b0;
        end else if (load) begin
            m_out <= int'(load_val); m_start <= int'(load_val); m_cnt <= 0;
            m_pd <= 1'b0; m_lk <= 1'b0;
        end else if (en && m_out == 0) begin
            m_out <= 1; m_start <= 1; m_cnt <= 0;
            m_pd <= 1'b0; m_lk <= 1'b1;
        end else if (en) begin
            m_out <= next_val(m_out);
            m_lk  <= 1'b0;
            if (next_val(m_out) == m_start) begin
                m_plen <= (m_cnt + 1) % MOD;
                m_cnt  <= 0;
                m_pd   <= 1'b1;
            end else begin
                m_cnt  <= (m_cnt + 1) % MOD;
                m_pd   <= 1'b0;
            end
        end else begin
            m_pd <= 1'b0; m_lk <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Single compare process against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_out",        32'(out),         32'(m_out));
        check("model_out_offset", 32'(out_offset),  32'(m_out + MOD));
        check("model_step_cnt",   32'(step_cnt),    32'(m_cnt));
        check("model_period_len", 32'(period_len),  32'(m_plen));
        check("model_period_done", 32'(period_done), 32'(m_pd));
        check("model_lockup",     32'(lockup),      32'(m_lk));
        if (period_done === 1'b1) pd_pulses++;
    end

    // Apply one set of inputs across one rising edge, then settle 1 ns.
    task automatic drive(input logic e, input logic l, input logic [W-1:0] v);
        en = e; load = l; load_val = v;
        @(posedge clk);
        #1;
        if (verbose)
            $display("txn en=%0b load=%0b val=%03h -> out=%03h cnt=%0d plen=%0d pd=%0b lk=%0b",
                     e, l, v, out, step_cnt, period_len, period_done, lockup);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [W-1:0] exp_seq [4];
    logic [W-1:0] prev;

    initial begin
        exp_seq[0] = 12'h003; exp_seq[1] = 12'h007; exp_seq[2] = 12'h00F; exp_seq[3] = 12'h01E;
        rst = 1'b1; en = 1'b0; load = 1'b0; load_val = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out",        32'(out),        32'h001);
        check("reset_out_offset", 32'(out_offset), 32'd4097);
        check("reset_step_cnt",   32'(step_cnt),   32'd0);
        check("reset_period_len", 32'(period_len), 32'd0);

        // Reset held: en/load must have no effect.
        drive(1'b1, 1'b1, 12'h005);
        drive(1'b1, 1'b0, 12'h000);
        check("reset_hold_out", 32'(out), 32'h001);
        check("reset_hold_cnt", 32'(step_cnt), 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 12'h000);
        check("idle_out", 32'(out), 32'h001);

        // First four steps from SEED.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 12'h000);
            check($sformatf("seq_step%0d", i), 32'(out), 32'(exp_seq[i]));
        end
        check("seq_step_cnt", 32'(step_cnt), 32'd4);

        // Complete the full maximal-length period (4095 steps total).
        verbose = 1'b0;
        repeat (4090) drive(1'b1, 1'b0, 12'h000);
        check("pre_period_pd", 32'(period_done), 32'd0);
        verbose = 1'b1;
        drive(1'b1, 1'b0, 12'h000);
        check("period_out",  32'(out),         32'h001);
        check("period_len",  32'(period_len),  32'd4095);
        check("period_cnt",  32'(step_cnt),    32'd0);
        check("period_pd",   32'(period_done), 32'd1);
        drive(1'b0, 1'b0, 12'h000);
        check("period_pd_drop", 32'(period_done), 32'd0);
        check("period_pulses",  32'(pd_pulses),   32'd1);
        check("period_len_hold", 32'(period_len), 32'd4095);

        // 100 more steps, then an asynchronous reset between edges.
        verbose = 1'b0;
        repeat (100) drive(1'b1, 1'b0, 12'h000);
        verbose = 1'b1;
        check("steps100_cnt", 32'(step_cnt), 32'd100);
        #2 rst = 1'b1;
        #1;
        check("async_out",  32'(out),         32'h001);
        check("async_cnt",  32'(step_cnt),    32'd0);
        check("async_plen", 32'(period_len),  32'd0);
        check("async_pd",   32'(period_done), 32'd0);
        check("async_lk",   32'(lockup),      32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b1, 1'b0, 12'h000);
        check("post_reset_step", 32'(out), 32'h003);

        // Load wins over en; then a normal step from the loaded value.
        drive(1'b1, 1'b1, 12'h0A5);
        check("load_out", 32'(out),      32'h0A5);
        check("load_cnt", 32'(step_cnt), 32'd0);
        drive(1'b1, 1'b0, 12'h000);
        check("load_step", 32'(out), 32'h14A);

        // Zero load then recovery.
        drive(1'b0, 1'b1, 12'h000);
        check("zero_load", 32'(out), 32'h000);
        drive(1'b1, 1'b0, 12'h000);
        check("recover_out", 32'(out),    32'h001);
        check("recover_lk",  32'(lockup), 32'd1);
        check("recover_cnt", 32'(step_cnt), 32'd0);
        drive(1'b1, 1'b0, 12'h000);
        check("recover_step", 32'(out),    32'h003);
        check("recover_lk_drop", 32'(lockup), 32'd0);

        // en toggled every cycle from a fresh start point.
        drive(1'b0, 1'b1, 12'h001);
        for (int i = 0; i < 20; i++) begin
            prev = out;
            drive((i % 2) == 0, 1'b0, 12'h000);
            if ((i % 2) != 0) check($sformatf("toggle_hold%0d", i), 32'(out), 32'(prev));
        end
        check("toggle_cnt", 32'(step_cnt), 32'd10);

        // Full period from a loaded non-seed start point.
        drive(1'b0, 1'b1, 12'h0A5);
        verbose = 1'b0;
        repeat (4095) drive(1'b1, 1'b0, 12'h000);
        verbose = 1'b1;
        check("load_period_out",  32'(out),         32'h0A5);
        check("load_period_len",  32'(period_len),  32'd4095);
        check("load_period_pd",   32'(period_done), 32'd1);
        drive(1'b0, 1'b0, 12'h000);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 12, register width; legal range 3..16.
REQ-002 Parameter TAPS, default 12'h829, WIDTH-bit feedback mask; bit i set means state[i] feeds the XOR.
REQ-003 Parameter SEED, default 1, WIDTH-bit reset/recovery value; SHALL be nonzero.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 en  input  1  advance the sequence one step this cycle.
REQ-007 load  input  1  load load_val this cycle.
REQ-008 load_val  input  WIDTH  value to load.
REQ-009 out  output  WIDTH  current LFSR state, registered.
REQ-010 out_offset  output  WIDTH+1  out + 2^WIDTH, zero-extended.
REQ-011 step_cnt  output  WIDTH  steps taken since the last start point.
REQ-012 period_len  output  WIDTH  step_cnt value captured at the last period completion.
REQ-013 period_done  output  1  one-cycle pulse on period completion.
REQ-014 lockup  output  1  one-cycle pulse on all-zero recovery.

Function
REQ-015 Fibonacci form: fb = XOR-reduce(out & TAPS); a step sets out <= {out[WIDTH-2:0], fb}.
REQ-016 Per-edge priority: rst > load > lockup recovery > en step > hold.
REQ-017 load: out <= load_val, start <= load_val, step_cnt <= 0, period_done <= 0, lockup <= 0; en is ignored that cycle.
REQ-018 Load of an all-zero value is accepted; recovery follows per REQ-019 on the next en cycle.
REQ-019 Lockup recovery: when out == 0 and en == 1 and load == 0:
  - out <= SEED, start <= SEED, step_cnt <= 0;
  - lockup = 1 for exactly the following cycle;
  - no step is taken.
REQ-020 Step: step_cnt <= step_cnt + 1, wrapping modulo 2^WIDTH.
REQ-021 Period completion: if the next stepped value equals start:
  - period_done = 1 for the following cycle;
  - period_len <= step_cnt + 1 (mod 2^WIDTH);
  - step_cnt <= 0.
REQ-022 Period rule for maximal-length TAPS: a full period of 2^WIDTH-1 steps reports period_len = 2^WIDTH-1.
REQ-023 When en == 0 and load == 0: out, step_cnt, start and period_len hold; period_done and lockup are 0.
REQ-024 out_offset is combinational from out: {1'b1, out}.
REQ-025 Latency: out reflects a step, load or recovery on the edge that samples it, with no further delay.

Reset
REQ-026 On rst assertion, with no clock edge required, SHALL set:
  - out = SEED, start = SEED;
  - step_cnt = 0, period_len = 0;
  - period_done = 0, lockup = 0.
REQ-027 Reset asserted mid-sequence or mid-pulse SHALL immediately abort; the first step after deassertion starts from SEED.
REQ-028 Outputs SHALL hold reset values while rst is high, regardless of en or load.

Verification (WIDTH=12, TAPS=12'h829, SEED=1)
REQ-029 Reset, then en=1 for 4 cycles -> out = 001, 003, 007, 00F, 01E; out_offset starts at 4097.
REQ-030 en=1 continuously for 4095 steps from reset -> out returns to 001, period_done pulses once, period_len = 4095, step_cnt = 0.
REQ-031 load=1 with load_val=0x0A5 and en=1 in the same cycle -> out = 0x0A5, step_cnt = 0, no step; next en step -> out = 0x14A.
REQ-032 load_val=0, then en=1 -> out = 001 and lockup pulses for one cycle; next en step -> out = 003.
REQ-033 en toggled 1/0 every cycle for 20 cycles -> out advances only on en=1 cycles; step_cnt = 10.
REQ-034 rst pulsed asynchronously (between edges) after 100 steps -> out = 001 and step_cnt = 0 before the next edge; period_len and flags = 0.
